el_frame_sched: RTL and testbench

Ping-pong frame-bank scheduler between the HDMI-side writer (display_ctrl) and the EL panel scanner (timing_gen). It owns the `frame` bank-select bit for both RAMs, decides when a completed frame becomes visible, and swaps only at panel frame boundaries so the panel never tears. It blanks the panel until the first complete frame arrives and again when the source stalls. It keeps saturating drop and repeat statistics for debug. All writer and scanner event pulses are already synchronized into `clk`.

---
 rtl/el_frame_sched.sv | 130 +++++++++++++
 tb/tb_el_frame_sched.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/el_frame_sched.sv
// el_frame_sched: ping-pong bank scheduler between the frame writer and the
// panel scanner. Swaps banks only at panel frame starts, blanks the panel
// until a complete frame is available or when the source stalls, and keeps
// saturating drop/repeat statistics.
//
// state | meaning
// NOSIG | no frame shown since enable/reset; panel blanked
// SCAN  | showing a valid frame
// STALE | source stalled for TIMEOUT_FRAMES panel frames; panel blanked
// IDLE  | scan disabled (en=0); panel blanked, bank logic keeps running
module el_frame_sched #(
  parameter int TIMEOUT_FRAMES = 8,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_start,
  input  logic             wr_done,
  input  logic             scan_start,
  output logic             rd_bank,
  output logic             wr_bank,
  output logic             blank,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [CNT_W-1:0] frames_repeated
);

  typedef enum logic [1:0] {
    NOSIG = 2'd0,
    SCAN  = 2'd1,
    STALE = 2'd2,
    IDLE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_FRAMES);

  state_t           state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic             blank_q, blank_d;
  logic             ready_q, ready_d;
  logic             wr_active_q, wr_active_d;
  logic [7:0]       stale_q, stale_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             done_eff;
  logic             swap;
  logic             repeat_frame;

  // Bank bookkeeping: a completing frame is credited before any same-cycle
  // swap or restart is considered, so wr_done+scan_start swaps immediately.
  // A swap shows the ready frame, so a wr_start in the same cycle drops nothing.
  always_comb begin
    done_eff     = wr_done & wr_active_q;
    swap         = scan_start & (ready_q | done_eff);
    repeat_frame = scan_start & ~swap & ((state_q == SCAN) || (state_q == STALE));

    ready_d     = ready_q | done_eff;
    wr_active_d = wr_active_q & ~done_eff;
    rd_bank_d   = rd_bank_q;
    stale_d     = stale_q;
    drop_d      = drop_q;
    rep_d       = rep_q;

    if (swap) begin
      rd_bank_d = ~rd_bank_q;
      ready_d   = 1'b0;
      stale_d   = 8'd0;
    end

    if (wr_start) begin
      if (ready_d && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + 1'b1;
      ready_d     = 1'b0;
      wr_active_d = 1'b1;
    end

    if (repeat_frame) begin
      if (rep_q != {CNT_W{1'b1}}) rep_d = rep_q + 1'b1;
      if (stale_q != 8'hFF)       stale_d = stale_q + 1'b1;
    end
  end

  // Panel state machine; disabling scan overrides everything else.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = NOSIG;
        NOSIG:   if (swap) state_d = SCAN;
        SCAN:    if (stale_d >= TIMEOUT_LIM) state_d = STALE;
        STALE:   if (swap) state_d = SCAN;
        default: state_d = NOSIG;
      endcase
    end
    blank_d = (state_d != SCAN);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NOSIG;
      rd_bank_q   <= 1'b1;
      blank_q     <= 1'b1;
      ready_q     <= 1'b0;
      wr_active_q <= 1'b0;
      stale_q     <= 8'd0;
      drop_q      <= '0;
      rep_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      blank_q     <= blank_d;
      ready_q     <= ready_d;
      wr_active_q <= wr_active_d;
      stale_q     <= stale_d;
      drop_q      <= drop_d;
      rep_q       <= rep_d;
    end
  end

  assign rd_bank         = rd_bank_q;
  assign wr_bank         = ~rd_bank_q;
  assign blank           = blank_q;
  assign state           = state_q;
  assign frames_dropped  = drop_q;
  assign frames_repeated = rep_q;

endmodule

// File: tb/tb_el_frame_sched.sv
// Testbench for el_frame_sched: scenario-driven scoreboard. Each step pushes
// its expected outputs, then the outputs are popped and compared one cycle
// after the causing pulse.
module tb_el_frame_sched;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          wr_start = 1'b0;
  logic          wr_done = 1'b0;
  logic          scan_start = 1'b0;
  logic          rd_bank, wr_bank, blank;
  logic [1:0]    state;
  logic [CW-1:0] frames_dropped, frames_repeated;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  localparam int S_RD = 0, S_WR = 1, S_BLANK = 2, S_STATE = 3, S_DROP = 4, S_REP = 5;

  el_frame_sched #(.TIMEOUT_FRAMES(8), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .wr_start        (wr_start),
    .wr_done         (wr_done),
    .scan_start      (scan_start),
    .rd_bank         (rd_bank),
    .wr_bank         (wr_bank),
    .blank           (blank),
    .state           (state),
    .frames_dropped  (frames_dropped),
    .frames_repeated (frames_repeated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input int exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  function automatic int observe(input int sel);
    case (sel)
      S_RD:    return int'(rd_bank);
      S_WR:    return int'(wr_bank);
      S_BLANK: return int'(blank);
      S_STATE: return int'(state);
      S_DROP:  return int'(frames_dropped);
      default: return int'(frames_repeated);
    endcase
  endfunction

  task automatic drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      chk(it.tag, observe(it.sel), it.exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ws();
    wr_start = 1'b1; cyc(); wr_start = 1'b0; cyc();
  endtask
  task automatic pulse_wd();
    wr_done = 1'b1; cyc(); wr_done = 1'b0; cyc();
  endtask
  task automatic pulse_ss();
    scan_start = 1'b1; cyc(); scan_start = 1'b0;
  endtask

  task automatic push_view(input string tag, input int rd, input int bl, input int st);
    push({tag, ".rd"}, S_RD, rd);
    push({tag, ".wr"}, S_WR, 1 - rd);
    push({tag, ".blank"}, S_BLANK, bl);
    push({tag, ".state"}, S_STATE, st);
  endtask

  initial begin
    // Reset values
    cyc(2);
    push_view("reset", 1, 1, 0);
    push("reset.drop", S_DROP, 0);
    push("reset.rep", S_REP, 0);
    drain();

    // No source: stays blank in NOSIG, no repeats counted
    en = 1'b1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(20);
      pulse_ss();
      push_view("nosig", 1, 1, 0);
      push("nosig.rep", S_REP, 0);
      drain();
    end

    // First complete frame is swapped in
    pulse_ws(); pulse_wd(); cyc(3);
    pulse_ss();
    push_view("first", 0, 0, 1);
    drain();

    // Three frames between scans: two dropped, one swap
    for (int i = 0; i < 3; i++) begin
      pulse_ws(); pulse_wd();
    end
    push("three.drop", S_DROP, 2);
    drain();
    pulse_ss();
    push_view("three", 1, 0, 1);
    drain();
    cyc(5);
    pulse_ss();
    push_view("three.norepswap", 1, 0, 1);
    push("three.rep", S_REP, 1);
    drain();

    // wr_done coincident with scan_start still swaps
    pulse_ws(); cyc(3);
    wr_done = 1'b1; scan_start = 1'b1; cyc();
    wr_done = 1'b0; scan_start = 1'b0;
    push_view("coinc", 0, 0, 1);
    push("coinc.rep", S_REP, 1);
    drain();

    // Stall: 8 repeats, STALE on the 8th
    for (int i = 1; i <= 8; i++) begin
      cyc(4);
      pulse_ss();
      if (i == 8) push_view("stale8", 0, 1, 2);
      else if (i == 7) push_view("stale7", 0, 0, 1);
      push("stale.rep", S_REP, 1 + i);
      drain();
    end
    pulse_ws(); pulse_wd();
    pulse_ss();
    push_view("recover", 1, 0, 1);
    push("recover.rep", S_REP, 9);
    drain();

    // Disable then re-enable: IDLE, then NOSIG until next swap
    cyc(3);
    en = 1'b0; cyc();
    push_view("idle", 1, 1, 3);
    drain();
    en = 1'b1; cyc();
    push_view("reen", 1, 1, 0);
    drain();
    pulse_ss();
    push_view("reen.noswap", 1, 1, 0);
    push("reen.rep", S_REP, 9);
    drain();
    pulse_ws(); pulse_wd();
    pulse_ss();
    push_view("reen.swap", 0, 0, 1);
    drain();

    // Reset during an active writer frame discards it
    pulse_ws();
    rst = 1'b1; cyc(); rst = 1'b0;
    push_view("rstmid", 1, 1, 0);
    push("rstmid.drop", S_DROP, 0);
    push("rstmid.rep", S_REP, 0);
    drain();
    pulse_wd();
    pulse_ss();
    push_view("rstmid.noswap", 1, 1, 0);
    drain();

    // Repeat counter saturates at all-ones
    pulse_ws(); pulse_wd();
    pulse_ss();
    push_view("sat.swap", 0, 0, 1);
    drain();
    for (int i = 0; i < 20; i++) begin
      cyc(2);
      pulse_ss();
    end
    push("sat.rep", S_REP, 15);
    push_view("sat.view", 0, 1, 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
